demux_reg_1to2: RTL
===================

// Module: demux_reg_1to2
//
// PURPOSE
// - Registered 1:2 stream demultiplexer: the inverse of the team's 2:1 selector.
// - One input stream is steered to out1 (sel=1) or out2 (sel=0).
// - Each output has a one-entry holding register with a valid/ready handshake.
// - Sits between a single producer and two consumers.
// - A stalled consumer blocks only traffic that is steered to it.
//
// PARAMETERS
// - WIDTH   2   data width of in_data, out1_data, out2_data (legal range 1..32)
//
// PORTS
// - clk         in   1      single clock; all state updates on the rising edge
// - rst         in   1      synchronous reset, active-high
// - in_data     in   WIDTH  input payload
// - in_valid    in   1      in_data and sel are valid this cycle
// - in_ready    out  1      block accepts in_data this cycle (combinational)
// - sel         in   1      1 = route to out1, 0 = route to out2
// - out1_data   out  WIDTH  payload held in slot 1
// - out1_valid  out  1      slot 1 full
// - out1_ready  in   1      consumer 1 accepts out1_data
// - out2_data   out  WIDTH  payload held in slot 2
// - out2_valid  out  1      slot 2 full
// - out2_ready  in   1      consumer 2 accepts out2_data
// - cnt1        out  8      transfers completed on out1 (only with DEMUX_CNT_EN)
// - cnt2        out  8      transfers completed on out2 (only with DEMUX_CNT_EN)
//
// BEHAVIOUR
// - Each slot is a 2-state FSM: EMPTY (valid=0) / FULL (valid=1).
// - Reset (rst=1 at an edge): both slots go EMPTY, outN_data=0, cnt1=cnt2=0.
//   - Reset overrides any transfer in the same cycle, including a mid-handshake one.
// - Drain of slot N: outN_valid & outN_ready at an edge.
// - Load of slot N: in_valid & in_ready with sel selecting N.
// - in_ready = (selected slot EMPTY) | (selected slot draining this cycle).
//   - Combinational from sel, the slot state and the selected outN_ready.
//   - in_ready does not depend on in_valid.
// - Latency: accepted data appears on outN_data with outN_valid=1 on the next cycle.
// - Slot transitions at each edge:
//   - EMPTY -> FULL on load.
//   - FULL -> EMPTY on drain without load.
//   - FULL stays FULL on drain + load in the same cycle; new data replaces old.
//     Full throughput: 1 word/cycle per output.
//   - FULL without drain: holds data and valid.
// - Loading one slot never disturbs the other slot; both may drain in the same cycle.
// - outN_data is stable while outN_valid=1 and no drain occurs.
// - Producer rule: hold in_data and sel stable while in_valid=1 and in_ready=0.
// - If sel changes while stalled, in_ready re-evaluates against the newly selected slot.
//   No data is lost or duplicated.
// - No width conversion: data passes bit-exact.
//
// CONFIGURATION
// - Macro DEMUX_CNT_EN.
// - Defined:
//   - Ports cnt1/cnt2 exist.
//   - cntN increments by 1 on every drain of slot N; wraps 255 -> 0.
//   - cntN clears on rst.
// - Undefined:
//   - Ports cnt1/cnt2 and their counter logic are absent.
//   - All other behaviour is identical.
//
// TESTING
// - Reset: drive rst=1 for 2 cycles with in_valid=1 -> out1_valid=out2_valid=0, data=0, cnt=0.
// - Route:
//   - sel=1, in_data=2'b10, in_valid=1, out1_ready=0 -> next cycle out1_valid=1, out1_data=2'b10.
//   - out2_valid stays 0.
// - Backpressure:
//   - Slot 1 full, out1_ready=0, sel=1, in_data=2'b01 -> in_ready=0.
//   - out1_data stays 2'b10.
//   - Then sel=0 -> in_ready=1; 2'b01 lands in out2.
// - Streaming:
//   - out1_ready=1 constantly; drive sel=1 with 3,2,1,0 on consecutive cycles.
//   - in_ready stays 1; out1 emits 3,2,1,0 each one cycle later.
// - Mid-operation reset: rst=1 while out2_valid=1 and a load to out2 is in progress -> out2_valid=0 next cycle.
// - Counter (DEMUX_CNT_EN): 257 drains on out2 -> cnt2=1, cnt1=0.

Source files
------------

// File: rtl/demux_reg_1to2_if.sv
// demux_reg_1to2_if
//
// Purpose: bundles the producer-side stream and the two consumer-side
// streams of the registered 1:2 demultiplexer into one interface.
//
// Signals:
//   in_data / in_valid / in_ready / sel   producer stream plus route select
//   out1_data / out1_valid / out1_ready   consumer 1 stream (sel = 1)
//   out2_data / out2_valid / out2_ready   consumer 2 stream (sel = 0)
//
// Modports:
//   slave  - the demultiplexer's view (drives in_ready and the out* data/valid)
//   master - the surrounding environment's view (producer plus both consumers)

interface demux_reg_1to2_if #(
    parameter int WIDTH = 2
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             sel;
    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out2_data;
    logic             out2_valid;
    logic             out2_ready;

    modport slave (
        input  in_data, in_valid, sel, out1_ready, out2_ready,
        output in_ready, out1_data, out1_valid, out2_data, out2_valid
    );

    modport master (
        output in_data, in_valid, sel, out1_ready, out2_ready,
        input  in_ready, out1_data, out1_valid, out2_data, out2_valid
    );
endinterface

// File: rtl/demux_reg_1to2.sv
// demux_reg_1to2
//
// Purpose: registered 1:2 stream demultiplexer. One input stream is steered
// to out1 (sel = 1) or out2 (sel = 0). Each output owns a one-entry holding
// slot with a valid/ready handshake, so a stalled consumer only blocks the
// traffic that is steered towards it. A slot that drains and loads in the
// same cycle stays full, which gives one word per cycle per output.
//
// Ports:
//   clk   - single clock, rising edge
//   rst   - synchronous reset, active-high (empties both slots, clears data)
//   bus   - demux_reg_1to2_if.slave (input stream, sel, both output streams)
//   cnt1  - 8-bit count of transfers completed on out1 (DEMUX_CNT_EN only)
//   cnt2  - 8-bit count of transfers completed on out2 (DEMUX_CNT_EN only)
//
// Configuration:
//   DEMUX_CNT_EN - when defined, adds the cnt1/cnt2 ports and their wrapping
//                  drain counters. When undefined they are absent entirely.

module demux_reg_1to2 #(
    parameter int WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    demux_reg_1to2_if.slave        bus
`ifdef DEMUX_CNT_EN
    ,
    output logic [7:0]             cnt1,
    output logic [7:0]             cnt2
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    slot_state_e      state1_q, state1_d;
    slot_state_e      state2_q, state2_d;
    logic [WIDTH-1:0] data1_q, data1_d;
    logic [WIDTH-1:0] data2_q, data2_d;

    logic drain1, drain2;
    logic load1, load2;
    logic in_ready;

    // A slot can take a new word when it is empty or when its current word
    // leaves on this same edge. in_ready looks only at the selected slot and
    // never at in_valid, so the producer can present data based on it.
    always_comb begin
        drain1   = (state1_q == FULL) && bus.out1_ready;
        drain2   = (state2_q == FULL) && bus.out2_ready;
        in_ready = bus.sel ? ((state1_q == EMPTY) || drain1)
                           : ((state2_q == EMPTY) || drain2);
        load1    = bus.in_valid && in_ready && bus.sel;
        load2    = bus.in_valid && in_ready && !bus.sel;
    end

    // Next-state for both slots. A load wins over a drain so that a
    // simultaneous drain + load keeps the slot full with the new word.
    always_comb begin
        state1_d = state1_q;
        data1_d  = data1_q;
        state2_d = state2_q;
        data2_d  = data2_q;

        if (load1) begin
            state1_d = FULL;
            data1_d  = bus.in_data;
        end else if (drain1) begin
            state1_d = EMPTY;
        end

        if (load2) begin
            state2_d = FULL;
            data2_d  = bus.in_data;
        end else if (drain2) begin
            state2_d = EMPTY;
        end
    end

    // Reset takes priority over any handshake completing on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state1_q <= EMPTY;
            state2_q <= EMPTY;
            data1_q  <= '0;
            data2_q  <= '0;
        end else begin
            state1_q <= state1_d;
            state2_q <= state2_d;
            data1_q  <= data1_d;
            data2_q  <= data2_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out1_valid = (state1_q == FULL);
    assign bus.out1_data  = data1_q;
    assign bus.out2_valid = (state2_q == FULL);
    assign bus.out2_data  = data2_q;

`ifdef DEMUX_CNT_EN
    logic [7:0] cnt1_q, cnt1_d;
    logic [7:0] cnt2_q, cnt2_d;

    // Counters advance on every completed output transfer and wrap at 255.
    always_comb begin
        cnt1_d = drain1 ? cnt1_q + 8'd1 : cnt1_q;
        cnt2_d = drain2 ? cnt2_q + 8'd1 : cnt2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt1_q <= 8'd0;
            cnt2_q <= 8'd0;
        end else begin
            cnt1_q <= cnt1_d;
            cnt2_q <= cnt2_d;
        end
    end

    assign cnt1 = cnt1_q;
    assign cnt2 = cnt2_q;
`endif

endmodule
